// File: rtl/alu_uart_ctrl.sv
// Sequencer between a UART and an external combinational ALU: collects an A, B, opcode
// byte triple, latches the ALU result and hands it to the transmitter.
module alu_uart_ctrl #(
  parameter int DBIT = 8,
  parameter int OPW  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic            tx_done_tick,
  input  logic [DBIT-1:0] alu_result,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [DBIT-1:0] a_reg, a_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [OPW-1:0]  op_reg, op_next;
  logic [DBIT-1:0] tx_data_reg, tx_data_next;
  logic            overrun_reg, overrun_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= WAIT_A;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      tx_data_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      op_reg      <= op_next;
      tx_data_reg <= tx_data_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    op_next      = op_reg;
    tx_data_next = tx_data_reg;
    overrun_next = overrun_reg;
    case (state_reg)
      WAIT_A: begin
        if (rx_done_tick) begin
          a_next     = rx_data;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          b_next     = rx_data;
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          op_next    = rx_data[OPW-1:0];
          state_next = CALC;
        end
      end
      // Operands settled on the previous edge, so the ALU output is valid here.
      CALC: begin
        tx_data_next = alu_result;
        state_next   = SEND;
      end
      SEND: begin
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_tick) begin
          state_next = WAIT_A;
        end
      end
      default: begin
        state_next = WAIT_A;
      end
    endcase
    // A byte arriving while a result is in flight is dropped and flagged.
    if (rx_done_tick && (state_reg == CALC || state_reg == SEND || state_reg == WAIT_TX)) begin
      overrun_next = 1'b1;
    end
  end

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_op   = op_reg;
  assign tx_data  = tx_data_reg;
  assign tx_start = (state_reg == SEND);
  assign busy     = (state_reg != WAIT_A);
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: stimulus pushes expected frames, a negedge monitor
// pops and checks them on every tx_start pulse.
module tb_alu_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_tx_start = 1'b0;

  alu_uart_ctrl #(.DBIT(8), .OPW(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .alu_result   (alu_result),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External ALU stand-in
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h21:   alu_result = alu_b;
      default: alu_result = 8'hFF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every tx_start is one frame result
  always @(negedge clk) begin
    if (tx_start) begin
      if (prev_tx_start) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_start_width: got 2+ cycles expected 1 (t=%0t)", $time);
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_start_unexpected: got pulse expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("frame a=%02h b=%02h op=%02h -> tx_data=%02h", alu_a, alu_b, alu_op, tx_data);
        chk("frame_alu_a", 32'(alu_a), 32'(e.a));
        chk("frame_alu_b", 32'(alu_b), 32'(e.b));
        chk("frame_alu_op", 32'(alu_op), 32'(e.op));
        chk("frame_tx_data", 32'(tx_data), 32'(e.res));
        chk("frame_latency_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_tx_start <= tx_start;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic with_tx_done);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tx_done_tick = with_tx_done;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
  endtask

  task automatic tx_done_pulse();
    tx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    tx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sends A, B, Op and queues the expected result; leaves the DUT in WAIT_TX.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte,
                       input logic [5:0] exp_op, input logic [7:0] exp_res);
    exp_t e;
    rx_byte(a, 1'b0);
    idle(1);
    rx_byte(b, 1'b0);
    rx_byte(op_byte, 1'b0);
    // cyc now counts the op edge; CALC is cycle 1, SEND (tx_start) cycle 2 -> seen before edge op+2
    e.a = a; e.b = b; e.op = exp_op; e.res = exp_res; e.cyc = cyc + 1;
    exp_q.push_back(e);
    idle(3);
    chk("busy_in_wait_tx", 32'(busy), 32'd1);
  endtask

  initial begin
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; tx_done_tick = 1'b0;
    idle(2);
    reset = 1'b0;
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // ADD, with a stray tx_done_tick while collecting operands
    rx_byte(8'h05, 1'b0);
    tx_done_pulse();
    chk("stray_tx_done_busy", 32'(busy), 32'd1);
    rx_byte(8'h03, 1'b0);
    rx_byte(8'h20, 1'b0);
    begin
      exp_t e;
      e.a = 8'h05; e.b = 8'h03; e.op = 6'h20; e.res = 8'h08; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    idle(3);
    tx_done_pulse();
    chk("add_done_busy", 32'(busy), 32'd0);

    // SUB wraps
    frame(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
    tx_done_pulse();
    chk("sub_done_busy", 32'(busy), 32'd0);

    // AND with upper opcode bits discarded
    frame(8'hF0, 8'h3C, 8'hE4, 6'h24, 8'h30);
    tx_done_pulse();

    // Undefined opcode
    frame(8'h12, 8'h34, 8'h3F, 6'h3F, 8'hFF);
    tx_done_pulse();
    chk("undef_done_busy", 32'(busy), 32'd0);
    chk("overrun_still_clear", 32'(overrun), 32'd0);

    // Overrun during WAIT_TX
    frame(8'hAA, 8'h55, 8'h20, 6'h20, 8'hFF);
    rx_byte(8'h77, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_alu_a_kept", 32'(alu_a), 32'hAA);
    chk("ovr_busy", 32'(busy), 32'd1);
    tx_done_pulse();
    frame(8'h01, 8'h02, 8'h25, 6'h25, 8'h03);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    tx_done_pulse();

    // rx and tx_done together in WAIT_TX: leave, drop byte
    frame(8'h10, 8'h20, 8'h20, 6'h20, 8'h30);
    rx_byte(8'h99, 1'b1);
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_alu_a_kept", 32'(alu_a), 32'h10);
    chk("both_overrun", 32'(overrun), 32'd1);
    idle(1);
    chk("both_still_idle", 32'(busy), 32'd0);

    do_reset();
    chk("rst2_overrun", 32'(overrun), 32'd0);
    chk("rst2_tx_data", 32'(tx_data), 32'h0);

    // Reset mid-frame, coinciding with a byte tick (reset wins)
    rx_byte(8'h09, 1'b0);
    chk("mid_alu_a", 32'(alu_a), 32'h09);
    reset = 1'b1;
    rx_data = 8'h55;
    rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_done_tick = 1'b0;
    chk("rstprio_alu_a", 32'(alu_a), 32'h0);
    chk("rstprio_busy", 32'(busy), 32'd0);
    frame(8'h02, 8'h04, 8'h21, 6'h21, 8'h04);
    tx_done_pulse();
    chk("final_busy", 32'(busy), 32'd0);

    idle(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
